cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle_if.sv | 28 ++
 rtl/cpu_multicycle.sv | 182 ++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_multicycle_if.sv
// Instruction-fetch and data-memory bus for cpu_multicycle.
// The CPU drives it through the master modport; the memories use the slave modport.
interface cpu_multicycle_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] instAddress;
  logic              instReq;
  logic [7:0]        instruction;
  logic              instValid;
  logic [DATA_W-1:0] memAddress;
  logic [DATA_W-1:0] memIn;
  logic              memWrEnable;
  logic              memReq;
  logic [DATA_W-1:0] memOut;
  logic              memReady;
  logic              instRetired;

  modport master (
    output instAddress, instReq, memAddress, memIn, memWrEnable, memReq, instRetired,
    input  instruction, instValid, memOut, memReady
  );

  modport slave (
    input  instAddress, instReq, memAddress, memIn, memWrEnable, memReq, instRetired,
    output instruction, instValid, memOut, memReady
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle 4-register CPU with 8-bit instructions.
// Each instruction takes FETCH and EXEC cycles; LOAD/STORE add MEM cycles until memReady.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_multicycle_if.master bus
);
  // state | meaning
  // FETCH | request instruction at PC; latch it into IR on instValid
  // EXEC  | commit LIM/ALU/CMP/BRL result, or pass LOAD/STORE on to MEM
  // MEM   | hold the data request until memReady; then commit load, advance PC
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_BRL   = 4'd7;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_ADD   = 4'd11;
  localparam logic [3:0] OP_NAND  = 4'd13;
  localparam logic [3:0] OP_MOV   = 4'd15;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_inc, w_target;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_regs [4];
  logic              r_z, r_c, r_rst_q;

  logic [3:0]        w_op;
  logic [1:0]        w_src, w_dst, w_wsel;
  logic [DATA_W-1:0] w_ra, w_rb, w_link, w_lim_val, w_wdata;
  logic [DATA_W:0]   w_diff;
  logic              w_z, w_c, w_taken;
  logic              w_ir_we, w_reg_we, w_flag_we;
  logic              w_inst_req, w_mem_req, w_mem_we, w_retired;

  assign w_op      = r_ir[3:0];
  assign w_src     = r_ir[5:4];
  assign w_dst     = r_ir[7:6];
  assign w_ra      = r_regs[w_src];
  assign w_rb      = r_regs[w_dst];
  assign w_diff    = {1'b0, w_ra} - {1'b0, w_rb};
  assign w_z       = (w_diff[DATA_W-1:0] == '0);
  assign w_c       = ~w_diff[DATA_W];
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_lim_val = {{(DATA_W-7){r_ir[7]}}, r_ir[7:1]};

  // Link value and branch target cross between the PC and register widths.
  generate
    if (ADDR_W >= DATA_W) begin : g_link_trunc
      assign w_link = w_pc_inc[DATA_W-1:0];
    end else begin : g_link_ext
      assign w_link = {{(DATA_W-ADDR_W){1'b0}}, w_pc_inc};
    end
    if (DATA_W >= ADDR_W) begin : g_tgt_trunc
      assign w_target = w_ra[ADDR_W-1:0];
    end else begin : g_tgt_ext
      assign w_target = {{(ADDR_W-DATA_W){1'b0}}, w_ra};
    end
  endgenerate

  always_comb begin
    case (w_dst)
      2'd0:    w_taken = ~r_c & ~r_z;
      2'd1:    w_taken = r_c & ~r_z;
      2'd2:    w_taken = r_z;
      default: w_taken = 1'b1;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_ir_we    = 1'b0;
    w_reg_we   = 1'b0;
    w_wsel     = w_dst;
    w_wdata    = '0;
    w_flag_we  = 1'b0;
    w_inst_req = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_retired  = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Fetch stays quiet in the first cycle after reset.
        if (!r_rst_q) begin
          w_inst_req = 1'b1;
          if (bus.instValid) begin
            w_ir_we = 1'b1;
            w_next  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_next    = S_FETCH;
        w_pc_next = w_pc_inc;
        w_retired = 1'b1;
        if (!r_ir[0]) begin
          w_reg_we = 1'b1;
          w_wsel   = 2'd3;
          w_wdata  = w_lim_val;
        end else begin
          case (w_op)
            OP_LOAD, OP_STORE: begin
              w_next    = S_MEM;
              w_pc_next = r_pc;
              w_retired = 1'b0;
            end
            OP_CMP: w_flag_we = 1'b1;
            OP_BRL: begin
              w_reg_we = 1'b1;
              w_wsel   = 2'd3;
              w_wdata  = w_link;
              if (w_taken) w_pc_next = w_target;
            end
            OP_SUB: begin
              w_reg_we = 1'b1;
              w_wdata  = w_diff[DATA_W-1:0];
            end
            OP_ADD: begin
              w_reg_we = 1'b1;
              w_wdata  = w_ra + w_rb;
            end
            OP_NAND: begin
              w_reg_we = 1'b1;
              w_wdata  = ~(w_ra & w_rb);
            end
            default: begin
              w_reg_we = 1'b1;
              w_wdata  = w_ra;
            end
          endcase
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_op == OP_STORE);
        if (bus.memReady) begin
          w_reg_we  = (w_op == OP_LOAD);
          w_wdata   = bus.memOut;
          w_pc_next = w_pc_inc;
          w_retired = 1'b1;
          w_next    = S_FETCH;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_rst_q <= 1'b1;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_rst_q <= 1'b0;
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (w_ir_we) r_ir <= bus.instruction;
      if (w_reg_we) r_regs[w_wsel] <= w_wdata;
      if (w_flag_we) begin
        r_z <= w_z;
        r_c <= w_c;
      end
    end
  end

  assign bus.instAddress = r_pc;
  assign bus.instReq     = w_inst_req;
  assign bus.memAddress  = w_ra;
  assign bus.memIn       = w_rb;
  assign bus.memReq      = w_mem_req;
  assign bus.memWrEnable = w_mem_we;
  assign bus.instRetired = w_retired & ~rst;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle: directed programs push expected retire/memory
// records; a monitor pops and compares them whenever the CPU retires or requests memory.
module tb_cpu_multicycle;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_multicycle_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] r0, r1, r2, r3;
    logic        z, c;
    int          lat;
  } ret_t;
  typedef struct {
    logic [15:0] addr, wd;
    logic        we;
    int          cyc;
    logic        abort;
  } mem_t;
  typedef struct {
    int          dly;
    logic [15:0] data;
  } rsp_t;

  ret_t ret_q[$];
  mem_t mem_q[$];
  rsp_t rsp_q[$];

  logic [7:0] prog [256];
  bit         pv   [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_ret(input logic [7:0] pc, input logic [15:0] r0, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] r3, input logic z,
                         input logic c, input int lat);
    ret_t e;
    e.pc = pc; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.z = z; e.c = c; e.lat = lat;
    ret_q.push_back(e);
  endtask

  task automatic exp_mem(input logic [15:0] addr, input logic [15:0] wd, input logic we,
                         input int cyc, input logic abort, input int dly, input logic [15:0] data);
    mem_t m;
    rsp_t r;
    m.addr = addr; m.wd = wd; m.we = we; m.cyc = cyc; m.abort = abort;
    r.dly = dly; r.data = data;
    mem_q.push_back(m);
    rsp_q.push_back(r);
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] ins);
    prog[a] = ins;
    pv[a]   = 1'b1;
  endtask

  // Memory model: instruction ROM plus a data port answering after a per-access delay.
  initial begin
    rsp_t cur;
    bit   m_act;
    int   m_cnt;
    m_act = 0; m_cnt = 0; cur.dly = 0; cur.data = '0;
    bus.instruction = '0; bus.instValid = 1'b0; bus.memOut = '0; bus.memReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.instruction = prog[bus.instAddress];
      bus.instValid   = pv[bus.instAddress];
      if (bus.memReq) begin
        if (!m_act) begin
          m_act = 1; m_cnt = 0;
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else begin cur.dly = 1000; cur.data = '0; end
        end
        m_cnt++;
        bus.memReady = (m_cnt > cur.dly);
        bus.memOut   = cur.data;
      end else begin
        m_act = 0;
        bus.memReady = 1'b0;
      end
    end
  end

  bit rst_s = 1'b1;
  initial forever begin
    @(posedge clk);
    rst_s = rst;
  end

  bit   pend = 0;
  ret_t cur_r;
  initial begin
    int   cyc;
    int   mcyc;
    bit   in_mem;
    bit   have_m;
    mem_t cur_m;
    cyc = 0; mcyc = 0; in_mem = 0; have_m = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("pc", 32'(bus.instAddress), 32'(cur_r.pc));
        chk("r0", 32'(dut.r_regs[0]), 32'(cur_r.r0));
        chk("r1", 32'(dut.r_regs[1]), 32'(cur_r.r1));
        chk("r2", 32'(dut.r_regs[2]), 32'(cur_r.r2));
        chk("r3", 32'(dut.r_regs[3]), 32'(cur_r.r3));
        chk("flag_z", 32'(dut.r_z), 32'(cur_r.z));
        chk("flag_c", 32'(dut.r_c), 32'(cur_r.c));
        pend = 0;
      end
      if (rst_s) cyc = 0;
      else cyc++;
      if (bus.memReq) begin
        if (!in_mem) begin
          in_mem = 1; mcyc = 0;
          if (mem_q.size() == 0) begin
            checks++; errors++; have_m = 0;
            $display("FAIL unexpected_mem_req: got memReq=1 expected none at %0t", $time);
          end else begin
            cur_m = mem_q.pop_front();
            have_m = 1;
          end
        end
        mcyc++;
        if (have_m) begin
          chk("mem_addr", 32'(bus.memAddress), 32'(cur_m.addr));
          chk("mem_wdata", 32'(bus.memIn), 32'(cur_m.wd));
          chk("mem_we", 32'(bus.memWrEnable), 32'(cur_m.we));
        end
        if (bus.memReady) begin
          if (have_m) begin
            chk("mem_req_cycles", 32'(mcyc), 32'(cur_m.cyc));
            chk("mem_completed_vs_abort", 32'(0), 32'(cur_m.abort));
          end
          in_mem = 0;
        end
      end else begin
        chk("we_outside_mem", 32'(bus.memWrEnable), 32'(0));
        if (in_mem) begin
          if (have_m) chk("mem_aborted", 32'(1), 32'(cur_m.abort));
          in_mem = 0;
        end
      end
      if (bus.instRetired) begin
        if (ret_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: got instRetired=1 expected none at %0t", $time);
        end else begin
          cur_r = ret_q.pop_front();
          chk("retire_latency", 32'(cyc), 32'(cur_r.lat));
          pend = 1;
        end
        cyc = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_instReq", 32'(bus.instReq), 32'(0));
    chk("rst_memReq", 32'(bus.memReq), 32'(0));
    chk("rst_memWrEnable", 32'(bus.memWrEnable), 32'(0));
    chk("rst_instRetired", 32'(bus.instRetired), 32'(0));
    chk("rst_instAddress", 32'(bus.instAddress), 32'(0));
    for (int i = 0; i < 4; i++) chk("rst_reg", 32'(dut.r_regs[i]), 32'(0));
    chk("rst_z", 32'(dut.r_z), 32'(0));
    chk("rst_c", 32'(dut.r_c), 32'(0));
    for (int i = 0; i < 256; i++) begin prog[i] = 8'h00; pv[i] = 1'b0; end
    rsp_q.delete();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("first_instReq", 32'(bus.instReq), 32'(1));
    chk("first_instAddress", 32'(bus.instAddress), 32'(0));
  endtask

  task automatic wait_done(input bit incl_mem);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ret_q.size() == 0 && !pend && (!incl_mem || mem_q.size() == 0)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d retires pending expected 0", ret_q.size());
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) begin prog[i] = 8'h00; pv[i] = 1'b0; end

    // Program A: LIM/ADD, MOV, CMP, BRL taken/not taken, SUB wrap, NAND, link-before-target.
    do_reset();
    put(8'h00, 8'h0A); put(8'h01, 8'hFB); put(8'h02, 8'h06); put(8'h03, 8'h3F);
    put(8'h04, 8'h7F); put(8'h05, 8'h40); put(8'h06, 8'hFB); put(8'h07, 8'hBF);
    put(8'h08, 8'h45); put(8'h09, 8'hA7); put(8'h40, 8'h67); put(8'h41, 8'hFE);
    put(8'h42, 8'hC9); put(8'h43, 8'hE9); put(8'h44, 8'h1D); put(8'h45, 8'h15);
    put(8'h46, 8'h37);
    exp_ret(8'h01, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 0, 0, 2);
    exp_ret(8'h02, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 0, 0, 2);
    exp_ret(8'h03, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 0, 0, 2);
    exp_ret(8'h04, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 0, 0, 2);
    exp_ret(8'h05, 16'h0003, 16'h0003, 16'h0000, 16'h0003, 0, 0, 2);
    exp_ret(8'h06, 16'h0003, 16'h0003, 16'h0000, 16'h0020, 0, 0, 2);
    exp_ret(8'h07, 16'h0003, 16'h0003, 16'h0000, 16'h0040, 0, 0, 2);
    exp_ret(8'h08, 16'h0003, 16'h0003, 16'h0040, 16'h0040, 0, 0, 2);
    exp_ret(8'h09, 16'h0003, 16'h0003, 16'h0040, 16'h0040, 1, 1, 2);
    exp_ret(8'h40, 16'h0003, 16'h0003, 16'h0040, 16'h000A, 1, 1, 2);
    exp_ret(8'h41, 16'h0003, 16'h0003, 16'h0040, 16'h0041, 1, 1, 2);
    exp_ret(8'h42, 16'h0003, 16'h0003, 16'h0040, 16'hFFFF, 1, 1, 2);
    exp_ret(8'h43, 16'h0003, 16'h0003, 16'h0040, 16'h0004, 1, 1, 2);
    exp_ret(8'h44, 16'h0003, 16'h0003, 16'h0040, 16'h003C, 1, 1, 2);
    exp_ret(8'h45, 16'hFFFC, 16'h0003, 16'h0040, 16'h003C, 1, 1, 2);
    exp_ret(8'h46, 16'hFFFC, 16'h0003, 16'h0040, 16'h003C, 0, 0, 2);
    exp_ret(8'h3C, 16'hFFFC, 16'h0003, 16'h0040, 16'h0047, 0, 0, 2);
    release_rst();
    wait_done(1);
    repeat (6) @(negedge clk);

    // Program B: LOAD with 3 wait cycles, LOAD with none, STORE 0xBEEF to 0x1234.
    do_reset();
    put(8'h00, 8'h01); put(8'h01, 8'h41); put(8'h02, 8'h43);
    exp_mem(16'h0000, 16'h0000, 0, 4, 0, 3, 16'h1234);
    exp_ret(8'h01, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 6);
    exp_mem(16'h1234, 16'h0000, 0, 1, 0, 0, 16'hBEEF);
    exp_ret(8'h02, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 3);
    exp_mem(16'h1234, 16'hBEEF, 1, 2, 0, 1, 16'hDEAD);
    exp_ret(8'h03, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 4);
    release_rst();
    wait_done(1);
    repeat (6) @(negedge clk);

    // Program C: jump to 0xFF, PC wraps to 0, then a LOAD that reset aborts mid-access.
    do_reset();
    put(8'h00, 8'h87); put(8'h01, 8'hFE); put(8'h02, 8'h7F); put(8'h03, 8'h40);
    put(8'h04, 8'h3F); put(8'h05, 8'h05); put(8'h06, 8'hD7); put(8'hFF, 8'hBF);
    put(8'h20, 8'h81);
    exp_ret(8'h01, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 2);
    exp_ret(8'h02, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 2);
    exp_ret(8'h03, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 2);
    exp_ret(8'h04, 16'h0000, 16'hFFFF, 16'h0000, 16'h0020, 0, 0, 2);
    exp_ret(8'h05, 16'h0020, 16'hFFFF, 16'h0000, 16'h0020, 0, 0, 2);
    exp_ret(8'h06, 16'h0020, 16'hFFFF, 16'h0000, 16'h0020, 1, 1, 2);
    exp_ret(8'hFF, 16'h0020, 16'hFFFF, 16'h0000, 16'h0007, 1, 1, 2);
    exp_ret(8'h00, 16'h0020, 16'hFFFF, 16'h0007, 16'h0007, 1, 1, 2);
    exp_ret(8'h20, 16'h0020, 16'hFFFF, 16'h0007, 16'h0001, 1, 1, 2);
    exp_mem(16'h0020, 16'h0007, 0, 0, 1, 1000, 16'h5555);
    release_rst();
    wait_done(0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.memReq) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL abort_setup: got memReq=0 expected 1");
    end
    repeat (3) @(negedge clk);
    do_reset();
    wait_done(1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
